// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_pipe_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__oai211_pipe_pkg: shared constants and configuration check
package gf180mcu_fd_sc_mcu7t5v0__oai211_pipe_pkg;
  `include "gf180mcu_fd_sc_mcu7t5v0__pipe_defs.vh"
  function automatic bit cfg_ok(int w, int d);
    return w >= 1 && w <= OAI211_PIPE_WIDTH_MAX && d >= OAI211_PIPE_DEPTH_MIN && d <= OAI211_PIPE_DEPTH_MAX;
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_func.sv
// gf180mcu_fd_sc_mcu7t5v0__oai211_func: single-bit OAI211, ZN = ~((A1|A2)&B&C)
module gf180mcu_fd_sc_mcu7t5v0__oai211_func (
  output logic ZN,
  input  logic A1,
  input  logic A2,
  input  logic B,
  input  logic C
);
  assign ZN = ~((A1 | A2) & B & C);
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pipe_defs.vh
// gf180mcu_fd_sc_mcu7t5v0__pipe_defs: legal configuration bounds and reset value for the OAI211 pipeline
localparam int OAI211_PIPE_DEPTH_MIN = 1;
localparam int OAI211_PIPE_DEPTH_MAX = 4;
localparam int OAI211_PIPE_WIDTH_MAX = 32;
localparam bit PIPE_RST_VAL = 1'b0;

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pipe_stage.sv
// gf180mcu_fd_sc_mcu7t5v0__pipe_stage: one data+valid stage with reset > scan > enable priority
module gf180mcu_fd_sc_mcu7t5v0__pipe_stage
  import gf180mcu_fd_sc_mcu7t5v0__oai211_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_se,
  input  logic             i_en,
  input  logic             i_si,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_dv,
  output logic [WIDTH-1:0] o_q,
  output logic             o_qv,
  output logic             o_so
);
  logic [WIDTH-1:0] r_q;
  logic             r_v;
  logic [WIDTH:0]   w_sh;
  // scan enters at bit 0 and leaves from the top bit; valid is not on the chain
  assign w_sh = {r_q, i_si};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= {WIDTH{PIPE_RST_VAL}};
      r_v <= PIPE_RST_VAL;
    end else if (i_se) begin
      r_q <= w_sh[WIDTH-1:0];
    end else if (i_en) begin
      r_q <= i_d;
      r_v <= i_dv;
    end
  end
  assign o_q  = r_q;
  assign o_qv = r_v;
  assign o_so = r_q[WIDTH-1];
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_pipe.sv
// gf180mcu_fd_sc_mcu7t5v0__oai211_pipe: WIDTH OAI211 channels followed by DEPTH scannable register stages
module gf180mcu_fd_sc_mcu7t5v0__oai211_pipe
  import gf180mcu_fd_sc_mcu7t5v0__oai211_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             R,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             IV,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] ZN,
  output logic             OV,
  output logic             SO
);
  if (!cfg_ok(WIDTH, DEPTH)) begin : g_bad_cfg
    $error("oai211_pipe: WIDTH must be 1..32 and DEPTH 1..4");
  end
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_q  [DEPTH];
  logic             w_v  [DEPTH];
  logic             w_so [DEPTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gf180mcu_fd_sc_mcu7t5v0__oai211_func u_f (
      .ZN(w_f[i]),
      .A1(A1[i]),
      .A2(A2[i]),
      .B (B[i]),
      .C (C[i])
    );
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_st
    logic [WIDTH-1:0] w_d;
    logic             w_dv;
    logic             w_si;
    if (k == 0) begin : g_head
      assign w_d  = w_f;
      assign w_dv = IV;
      assign w_si = SI;
    end else begin : g_link
      assign w_d  = w_q[k-1];
      assign w_dv = w_v[k-1];
      assign w_si = w_so[k-1];
    end
    gf180mcu_fd_sc_mcu7t5v0__pipe_stage #(.WIDTH(WIDTH)) u_s (
      .i_clk(CLK),
      .i_rst(R),
      .i_se (SE),
      .i_en (EN),
      .i_si (w_si),
      .i_d  (w_d),
      .i_dv (w_dv),
      .o_q  (w_q[k]),
      .o_qv (w_v[k]),
      .o_so (w_so[k])
    );
  end
  assign ZN = w_q[DEPTH-1];
  assign OV = w_v[DEPTH-1];
  assign SO = w_so[DEPTH-1];
`ifndef FUNCTIONAL
  specify
    (CLK *> ZN) = (1.0, 1.0);
    (CLK => OV) = (1.0, 1.0);
    (CLK => SO) = (1.0, 1.0);
    $setuphold(posedge CLK, A1, 1.0, 1.0);
    $setuphold(posedge CLK, A2, 1.0, 1.0);
    $setuphold(posedge CLK, B, 1.0, 1.0);
    $setuphold(posedge CLK, C, 1.0, 1.0);
    $setuphold(posedge CLK, IV, 1.0, 1.0);
    $setuphold(posedge CLK, EN, 1.0, 1.0);
    $setuphold(posedge CLK, SE, 1.0, 1.0);
    $setuphold(posedge CLK, SI, 1.0, 1.0);
    $setuphold(posedge CLK, R, 1.0, 1.0);
  endspecify
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai211_pipe.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__oai211_pipe: directed vectors checked against a bit-sequence model of the pipeline
module tb_gf180mcu_fd_sc_mcu7t5v0__oai211_pipe;
  localparam int W = 4;
  localparam int D = 2;
  logic         CLK = 1'b0;
  logic         R, IV, EN, SE, SI;
  logic [W-1:0] A1, A2, B, C;
  logic [W-1:0] ZN;
  logic         OV, SO;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W*D-1:0] mb;
  logic [D-1:0]   mv;
  bit             m_init = 0;

  gf180mcu_fd_sc_mcu7t5v0__oai211_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .R(R), .A1(A1), .A2(A2), .B(B), .C(C),
    .IV(IV), .EN(EN), .SE(SE), .SI(SI), .ZN(ZN), .OV(OV), .SO(SO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] oai(logic [W-1:0] a1, a2, b, c);
    logic [W-1:0] f;
    for (int i = 0; i < W; i++) f[i] = ~((a1[i] | a2[i]) & b[i] & c[i]);
    return f;
  endfunction

  // Model: pipeline contents as one bit sequence; bit p is stage p/W, channel p%W.
  // An enabled edge pushes a whole word in, a scan edge pushes one bit in.
  always @(posedge CLK) begin
    logic [W-1:0] ez, xm;
    if (R) begin
      mb = '0;
      mv = '0;
      m_init = 1;
    end else if (SE) begin
      mb = {mb[W*D-2:0], SI};
    end else if (EN) begin
      mb = {mb[W*(D-1)-1:0], oai(A1, A2, B, C)};
      mv = {mv[D-2:0], IV};
    end
    #1;
    if (m_init) begin
      ez = mb[W*D-1 -: W];
      for (int i = 0; i < W; i++) xm[i] = $isunknown(ez[i]);
      chk("model_zn", ZN & ~xm, ez & ~xm);
      chk("model_ov", OV, mv[D-1]);
      chk("model_so", SO, mb[W*D-1]);
    end
  end

  task automatic vec(logic [W-1:0] a1, a2, b, c, logic iv);
    A1 = a1; A2 = a2; B = b; C = c; IV = iv;
  endtask

  task automatic edge_;
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0] sbits;
    sbits = 8'b1100_1101;
    R = 1; SE = 1; EN = 1; SI = 0;
    vec(4'hF, 4'hF, 4'hF, 4'hF, 1);
    edge_();
    chk("reset_zn", ZN, 4'b0000);
    chk("reset_ov", OV, 1'b0);
    chk("reset_so", SO, 1'b0);
    R = 0; SE = 0;
    vec(4'b1010, 4'b0100, 4'b1111, 4'b1110, 1);
    edge_();
    chk("basic_lat1_zn", ZN, 4'b0000);
    chk("basic_lat1_ov", OV, 1'b0);
    vec(0, 0, 0, 0, 0);
    edge_();
    chk("basic_zn", ZN, 4'b0001);
    chk("basic_ov", OV, 1'b1);
    vec(4'b1111, 4'b0000, 4'b1111, 4'b0001, 1);
    edge_();
    vec(4'b0000, 4'b0011, 4'b0011, 4'b0010, 1);
    edge_();
    chk("v1_zn", ZN, 4'b1110);
    EN = 0;
    vec(4'hF, 4'hF, 4'hF, 4'hF, 1);
    for (int s = 0; s < 3; s++) begin
      edge_();
      chk("stall_zn", ZN, 4'b1110);
      chk("stall_ov", OV, 1'b1);
    end
    EN = 1;
    vec(0, 0, 0, 0, 0);
    edge_();
    chk("v2_zn", ZN, 4'b1101);
    chk("v2_ov", OV, 1'b1);
    edge_();
    chk("drain_zn", ZN, 4'b1111);
    chk("drain_ov", OV, 1'b0);
    vec(4'b1111, 4'b0000, 4'b1111, 4'b0001, 1);
    edge_();
    vec(4'b0000, 4'b0011, 4'b0011, 4'b0010, 1);
    edge_();
    SE = 1;
    vec(0, 0, 0, 0, 0);
    for (int s = 0; s < 8; s++) begin
      SI = sbits[s];
      EN = s[0];
      edge_();
      chk("scan_ov", OV, 1'b1);
    end
    chk("scan_so", SO, 1'b1);
    chk("scan_zn", ZN, 4'b1011);
    SE = 0; EN = 1; SI = 0;
    edge_();
    chk("post_scan_zn", ZN, 4'b0011);
    chk("post_scan_ov", OV, 1'b1);
    vec(4'b1111, 4'b0000, 4'b1111, 4'b0001, 1);
    edge_();
    R = 1;
    edge_();
    chk("midrst_zn", ZN, 4'b0000);
    chk("midrst_ov", OV, 1'b0);
    R = 0;
    vec(0, 0, 0, 0, 0);
    for (int s = 0; s < 2; s++) begin
      edge_();
      chk("no_stale_ov", OV, 1'b0);
    end
    vec(4'b0000, 4'b0011, 4'b0011, 4'b0010, 1);
    edge_();
    vec(0, 0, 0, 0, 0);
    edge_();
    chk("after_rst_zn", ZN, 4'b1101);
    chk("after_rst_ov", OV, 1'b1);
    vec(4'b0x00, 4'b0001, 4'b1111, 4'b1111, 1);
    edge_();
    vec(0, 0, 0, 0, 0);
    edge_();
    chk("xiso_zn", ZN & 4'b1011, 4'b1010);
    chk("xiso_ov", OV, 1'b1);
    chk("xiso_ov_known", {31'b0, $isunknown(OV)}, 0);
    for (int s = 0; s < 12; s++) begin
      EN = (s % 3) != 2;
      vec(4'(s * 3), 4'(s * 5 + 1), 4'(~s), 4'(s * 7 + 3), s[0]);
      edge_();
    end
    EN = 1;
    vec(0, 0, 0, 0, 0);
    edge_();
    edge_();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
